// File: rtl/serial_in_parallel_out.sv
// Receive-side deserializer for the TC serial link.
// Collects an MSB-first frame of WIDTH bits, marked by a one-cycle frame_start on the
// first bit, and offers the reassembled word through a valid/ready handshake. Overruns
// (a word completing while the previous one is still pending) and mid-frame frame_start
// events (resync) are flagged.
module serial_in_parallel_out #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_out,
  input  logic             reset,
  input  logic             sin,
  input  logic             frame_start,
  input  logic             out_ready,
  input  logic             clr_err,
  output logic [WIDTH-1:0] word_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun,
  output logic             sync_err
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;
  logic            sync_err_q, sync_err_d;

  logic [WIDTH-1:0] sr_shifted;
  logic             complete;

  assign sr_shifted = {sr_q[WIDTH-2:0], sin};

  // Frame FSM: tracks bit position, shifts data in, detects completion and resync.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    complete   = 1'b0;
    sync_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          sr_d    = sr_shifted;
          cnt_d   = CntW'(1);
          state_d = StShift;
        end
      end
      StShift: begin
        sr_d = sr_shifted;
        if (frame_start) begin
          // Resync: old bits age out of sr before the restarted frame completes.
          cnt_d      = CntW'(1);
          sync_err_d = 1'b1;
        end else if (cnt_q == LastCnt) begin
          complete = 1'b1;
          cnt_d    = '0;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Output side: hand completed words to the consumer, or drop them and flag overrun.
  always_comb begin
    word_d    = word_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (clr_err) begin
      overrun_d = 1'b0;
    end
    if (complete) begin
      if (!valid_q || out_ready) begin
        word_d  = sr_shifted;
        valid_d = 1'b1;
      end else begin
        // Set beats a coincident clear.
        overrun_d = 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sr_q       <= '0;
      word_q     <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign word_out  = word_q;
  assign out_valid = valid_q;
  assign busy      = (state_q == StShift);
  assign overrun   = overrun_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_serial_in_parallel_out.sv
// Bench for serial_in_parallel_out: directed frames, a per-cycle comparison against a
// bit-counting reference model, and literal checks that pin the model.
module tb_serial_in_parallel_out;

  logic        clk_out = 1'b0;
  logic        reset = 1'b0;
  logic        sin = 1'b0;
  logic        frame_start = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr_err = 1'b0;
  logic [31:0] word_out;
  logic        out_valid;
  logic        busy;
  logic        overrun;
  logic        sync_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  serial_in_parallel_out #(.WIDTH(32)) dut (
    .clk_out    (clk_out),
    .reset      (reset),
    .sin        (sin),
    .frame_start(frame_start),
    .out_ready  (out_ready),
    .clr_err    (clr_err),
    .word_out   (word_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .overrun    (overrun),
    .sync_err   (sync_err)
  );

  always #5 clk_out = ~clk_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: counts bits since the last frame marker and forms the word numerically.
  bit          m_in = 1'b0;
  int          m_n = 0;
  logic [31:0] m_bits = '0;
  logic [31:0] m_word = '0;
  bit          m_valid = 1'b0;
  bit          m_over = 1'b0;
  bit          m_sync = 1'b0;
  bit          m_done, m_was_valid, m_drop;

  always @(posedge clk_out or negedge reset) begin
    if (!reset) begin
      m_in = 0; m_n = 0; m_bits = '0; m_word = '0;
      m_valid = 0; m_over = 0; m_sync = 0;
    end else begin
      m_done      = 0;
      m_was_valid = m_valid;
      m_sync      = frame_start && m_in;
      if (frame_start) begin
        m_bits = 32'(sin);
        m_n    = 1;
        m_in   = 1;
      end else if (m_in) begin
        m_bits = m_bits * 2 + 32'(sin);
        m_n    = m_n + 1;
        if (m_n == 32) begin
          m_done = 1;
          m_in   = 0;
        end
      end
      m_drop = m_done && m_was_valid && !out_ready;
      if (m_drop) m_over = 1;
      else if (clr_err) m_over = 0;
      if (m_done && !m_drop) begin
        m_word  = m_bits;
        m_valid = 1;
      end else if (!m_done && m_was_valid && out_ready) begin
        m_valid = 0;
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk_out) begin
    if (cmp_on) begin
      chk("cyc.out_valid", 32'(out_valid), 32'(m_valid));
      chk("cyc.word_out", word_out, m_word);
      chk("cyc.busy", 32'(busy), 32'(m_in));
      chk("cyc.overrun", 32'(overrun), 32'(m_over));
      chk("cyc.sync_err", 32'(sync_err), 32'(m_sync));
    end
  end

  // Drive one cycle's inputs on the falling edge; the next rising edge samples them.
  task automatic cyc(input logic s, input logic fs, input logic rdy, input logic clr);
    @(negedge clk_out);
    sin = s; frame_start = fs; out_ready = rdy; clr_err = clr;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, rdy, 1'b0);
  endtask

  // Send a full frame; rdy applies to all bits except bit 0, which uses rdy_last.
  task automatic send_word(input logic [31:0] w, input logic rdy, input logic rdy_last);
    for (int i = 31; i >= 0; i--) cyc(w[i], i == 31, (i == 0) ? rdy_last : rdy, 1'b0);
  endtask

  task automatic after_edge();
    @(posedge clk_out);
    #1;
  endtask

  logic [31:0] w;

  initial begin
    #12;
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.word_out", word_out, 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.overrun", 32'(overrun), 32'd0);
    @(negedge clk_out);
    reset  = 1'b1;
    cmp_on = 1'b1;
    idle(2, 1'b1);

    // Single frame with the consumer ready.
    send_word(32'hA5A50F0F, 1'b1, 1'b1);
    after_edge();
    chk("single.valid", 32'(out_valid), 32'd1);
    chk("single.word", word_out, 32'hA5A50F0F);
    chk("single.busy_done", 32'(busy), 32'd0);
    idle(1, 1'b1);
    after_edge();
    chk("single.valid_1cyc", 32'(out_valid), 32'd0);
    idle(2, 1'b1);

    // Back-to-back frames, no gap.
    send_word(32'h00000001, 1'b1, 1'b1);
    after_edge();
    chk("b2b.word0", word_out, 32'h00000001);
    send_word(32'h80000000, 1'b1, 1'b1);
    after_edge();
    chk("b2b.word1", word_out, 32'h80000000);
    chk("b2b.valid1", 32'(out_valid), 32'd1);
    chk("b2b.overrun", 32'(overrun), 32'd0);
    idle(2, 1'b1);

    // Overrun: second word dropped while the first is pending.
    send_word(32'h12345678, 1'b0, 1'b0);
    send_word(32'hDEADBEEF, 1'b0, 1'b0);
    after_edge();
    chk("ovr.word", word_out, 32'h12345678);
    chk("ovr.flag", 32'(overrun), 32'd1);
    chk("ovr.valid", 32'(out_valid), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    after_edge();
    chk("ovr.accept", 32'(out_valid), 32'd0);
    chk("ovr.sticky", 32'(overrun), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    after_edge();
    chk("ovr.clear", 32'(overrun), 32'd0);
    idle(2, 1'b1);

    // Accept and complete on the same edge.
    send_word(32'h11111111, 1'b0, 1'b0);
    send_word(32'h22222222, 1'b0, 1'b1);
    after_edge();
    chk("simul.word", word_out, 32'h22222222);
    chk("simul.valid", 32'(out_valid), 32'd1);
    chk("simul.overrun", 32'(overrun), 32'd0);
    idle(2, 1'b1);

    // Resync at bit 15 of an aborted frame.
    w = 32'h0F0F0F0F;
    for (int i = 31; i >= 16; i--) cyc(w[i], i == 31, 1'b1, 1'b0);
    w = 32'hCAFEF00D;
    cyc(w[31], 1'b1, 1'b1, 1'b0);
    after_edge();
    chk("resync.pulse", 32'(sync_err), 32'd1);
    chk("resync.busy", 32'(busy), 32'd1);
    for (int i = 30; i >= 0; i--) cyc(w[i], 1'b0, 1'b1, 1'b0);
    after_edge();
    chk("resync.word", word_out, 32'hCAFEF00D);
    chk("resync.valid", 32'(out_valid), 32'd1);
    chk("resync.pulse_gone", 32'(sync_err), 32'd0);
    idle(2, 1'b1);

    // Reset mid-frame with a word pending.
    send_word(32'h5555AAAA, 1'b0, 1'b0);
    w = 32'h3C3C3C3C;
    for (int i = 31; i >= 22; i--) cyc(w[i], i == 31, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.word", word_out, 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.overrun", 32'(overrun), 32'd0);
    chk("rst.sync_err", 32'(sync_err), 32'd0);
    @(negedge clk_out);
    reset = 1'b1;
    idle(1, 1'b1);
    send_word(32'h0000FFFF, 1'b1, 1'b1);
    after_edge();
    chk("post_rst.word", word_out, 32'h0000FFFF);
    chk("post_rst.valid", 32'(out_valid), 32'd1);
    idle(3, 1'b1);

    @(posedge clk_out);
    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_in_parallel_out.md
# serial_in_parallel_out

Receive-side deserializer for the TC serial link. It consumes the MSB-first bit stream produced by the 32-bit serializer, using a one-cycle frame marker that the top module raises alongside the serializer's load. It reassembles each frame into a parallel word and hands the word to the slave-register side through a valid/ready handshake. The block also flags overruns and mid-frame resynchronisation events.

## Interface
- WIDTH, 32, frame length in bits; legal range 2..64.
- clk_out  input  1  link clock (tcclock); all state is on its rising edge.
- reset  input  1  asynchronous, active-low reset; deassertion is synchronous to clk_out upstream.
- sin  input  1  serial data, MSB first, one bit per clk_out cycle.
- frame_start  input  1  high for exactly the cycle in which sin carries bit WIDTH-1 of a frame.
- out_ready  input  1  consumer accepts word_out on any edge where out_valid=1 and out_ready=1.
- clr_err  input  1  synchronous clear of the overrun flag.
- word_out  output  WIDTH  last completed frame; stable while out_valid=1.
- out_valid  output  1  word_out holds an unconsumed frame.
- busy  output  1  a frame is partially received (state SHIFT).
- overrun  output  1  sticky; a frame completed while out_valid=1 and out_ready=0.
- sync_err  output  1  one-cycle pulse; frame_start arrived mid-frame.

## Operation
- States: IDLE and SHIFT. There is a bit counter cnt (ceil(log2 WIDTH) bits) and a WIDTH-bit shift register sr.
- IDLE with frame_start=1:
  - sr <= {sr[WIDTH-2:0], sin}, cnt <= 1, go to SHIFT.
  - In IDLE, sin is ignored when frame_start=0.
- SHIFT with frame_start=0:
  - sr shifts in sin and cnt increments.
  - When the sampled bit is bit 0 (cnt==WIDTH-1): the completed word is {sr[WIDTH-2:0], sin}. State goes to IDLE and cnt goes to 0.
- Completion delivery:
  - If out_valid=0, or out_valid=1 with out_ready=1 on the same edge: word_out <= completed word and out_valid <= 1.
  - Otherwise: the completed word is dropped, word_out is unchanged, and overrun <= 1.
- SHIFT with frame_start=1 (resync):
  - The partial frame is discarded.
  - sr restarts with the current sin as bit WIDTH-1 and cnt <= 1. State stays SHIFT.
  - sync_err pulses high for one cycle after that edge.
  - This also applies on the cycle that would have carried bit 0.
- Handshake:
  - out_valid falls on an edge with out_ready=1, unless a completion loads a new word on the same edge.
  - out_ready while out_valid=0 has no effect.
- overrun:
  - Set as described under completion delivery.
  - Cleared by clr_err=1 on an edge.
  - If a set and a clear coincide, set wins.
- busy equals (state==SHIFT).
- Reset (asynchronous, any time, including mid-frame):
  - State=IDLE, cnt=0, sr=0, word_out=0.
  - out_valid=0, busy=0, overrun=0, sync_err=0.
  - Any partial frame is lost.

## Timing
- Edge E0 is the edge where frame_start=1; it samples bit WIDTH-1.
- Bit 0 is sampled at edge E0+WIDTH-1.
- out_valid and word_out are visible after that edge, i.e. WIDTH-1 cycles after E0. Latency from last bit to valid is 0 extra cycles.
- Back-to-back frames: frame_start may be high on edge E0+WIDTH, the cycle right after completion. This gives a sustained rate of one word per WIDTH cycles with no gap.
- Minimum out_valid duration is 1 cycle when out_ready=1 is held. Throughput holds if out_ready is asserted at least once per WIDTH cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Single frame:
  - Stimulus: release reset, then send 0xA5A50F0F MSB first with frame_start on bit 31 and out_ready=1.
  - Required: word_out=0xA5A50F0F and out_valid=1 for exactly one cycle, 31 cycles after the frame_start edge. busy is high for 31 cycles.
- Back-to-back:
  - Stimulus: 0x00000001 then 0x80000000 with no gap, out_ready=1.
  - Required: two valid pulses 32 cycles apart with the correct words; no overrun, no sync_err.
- Overrun:
  - Stimulus: out_ready=0, send 0x12345678 then 0xDEADBEEF.
  - Required: word_out stays 0x12345678 and overrun=1. Raising out_ready drops out_valid. A clr_err pulse clears overrun.
- Simultaneous accept and complete:
  - Stimulus: hold out_valid with 0x11111111 and assert out_ready on the exact edge 0x22222222 completes.
  - Required: word_out=0x22222222, out_valid stays 1, overrun=0.
- Resync:
  - Stimulus: assert frame_start at bit 15 of a frame, then send 0xCAFEF00D from that point.
  - Required: one-cycle sync_err pulse; the next valid word is 0xCAFEF00D; no word is delivered for the aborted frame.
- Reset mid-frame:
  - Stimulus: assert reset low after 10 bits while out_valid=1.
  - Required: all outputs go to 0 immediately (asynchronously). After release, a fresh frame 0x0000FFFF is received correctly.
